// File: rtl/register_writeback_pkg.sv
// Shared pipeline definitions for the writeback stage.
// Register index width, register count and pending-count limits.
package register_writeback_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;
    localparam int CNT_MAX   = 3;
    localparam int CNT_W     = 2;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]     pend_cnt_t;

    function automatic logic cnt_at_max(pend_cnt_t c);
        return c == pend_cnt_t'(CNT_MAX);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Circular result queue holding {register index, value} pairs.
// Push and pop may share an edge, including when the queue is full.
module result_fifo
    import register_writeback_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  reg_idx_t         push_idx_i,
    input  logic [WIDTH-1:0] push_val_i,
    input  logic             pop_i,
    output reg_idx_t         head_idx_o,
    output logic [WIDTH-1:0] head_val_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [PTR_W:0]   count_o
);

    reg_idx_t         idx_mem_q [DEPTH];
    logic [WIDTH-1:0] val_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic do_push;
    logic do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
    assign count_o    = count_q;
    assign head_idx_o = idx_mem_q[rd_ptr_q];
    assign head_val_o = val_mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointers and count; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while not counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            idx_mem_q[wr_ptr_q] <= push_idx_i;
            val_mem_q[wr_ptr_q] <= push_val_i;
        end
    end

endmodule

// File: rtl/register_writeback.sv
// Writeback stage: result queue, registered register-file write
// port and per-register pending-producer scoreboard.
module register_writeback
    import register_writeback_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reserveValid,
    input  reg_idx_t               reserveIndex,
    output logic                   reserveReady,
    input  logic                   resultValid,
    input  reg_idx_t               resultIndex,
    input  logic [WIDTH-1:0]       resultValue,
    input  logic                   regWriteW,
    output logic                   resultReady,
    output logic                   writeEnable,
    output reg_idx_t               writeIndex,
    output logic [WIDTH-1:0]       writeValue,
    input  reg_idx_t               queryIndex1,
    input  reg_idx_t               queryIndex2,
    output logic                   flagOutput1,
    output logic                   flagOutput2,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   errorFlag
);

    pend_cnt_t cnt_q [NUM_REGS];
    pend_cnt_t cnt_d [NUM_REGS];

    logic             err_q, err_d;
    logic             we_q, we_d;
    reg_idx_t         widx_q, widx_d;
    logic [WIDTH-1:0] wval_q, wval_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    reg_idx_t         head_idx;
    logic [WIDTH-1:0] head_val;
    logic             rsv_acc;

    result_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (fifo_push),
        .push_idx_i(resultIndex),
        .push_val_i(resultValue),
        .pop_i     (fifo_pop),
        .head_idx_o(head_idx),
        .head_val_o(head_val),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (occupancy)
    );

    assign reserveReady = !((reserveIndex != '0) && cnt_at_max(cnt_q[reserveIndex]));
    assign rsv_acc      = reserveValid && reserveReady && (reserveIndex != '0);

    assign resultReady = !fifo_full;
    assign fifo_push   = resultValid && resultReady && regWriteW && (resultIndex != '0);
    assign fifo_pop    = !fifo_empty;

    assign flagOutput1 = (cnt_q[queryIndex1] == '0);
    assign flagOutput2 = (cnt_q[queryIndex2] == '0);

    assign writeEnable = we_q;
    assign writeIndex  = widx_q;
    assign writeValue  = wval_q;
    assign errorFlag   = err_q;

    // Head of the queue goes out on the write port for one cycle.
    always_comb begin
        we_d   = fifo_pop;
        widx_d = widx_q;
        wval_d = wval_q;
        if (fifo_pop) begin
            widx_d = head_idx;
            wval_d = head_val;
        end
    end

    // Reserve increments, committed write decrements; r0 never counts.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i != 0) begin
                if (rsv_acc && reserveIndex == reg_idx_t'(i)) begin
                    if (!(we_q && widx_q == reg_idx_t'(i))) begin
                        cnt_d[i] = cnt_q[i] + pend_cnt_t'(1);
                    end else if (cnt_q[i] == '0) begin
                        err_d = 1'b1;
                    end
                end else if (we_q && widx_q == reg_idx_t'(i)) begin
                    if (cnt_q[i] == '0) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - pend_cnt_t'(1);
                    end
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Scoreboard, error and write-port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            err_q  <= 1'b0;
            we_q   <= 1'b0;
            widx_q <= '0;
            wval_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            err_q  <= err_d;
            we_q   <= we_d;
            widx_q <= widx_d;
            wval_q <= wval_d;
        end
    end

endmodule

// File: tb/tb_register_writeback.sv
// Self-checking bench for register_writeback: directed scenarios
// followed by random traffic against a queue-based reference model.
module tb_register_writeback;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             reserveValid;
    logic [4:0]       reserveIndex;
    logic             reserveReady;
    logic             resultValid;
    logic [4:0]       resultIndex;
    logic [WIDTH-1:0] resultValue;
    logic             regWriteW;
    logic             resultReady;
    logic             writeEnable;
    logic [4:0]       writeIndex;
    logic [WIDTH-1:0] writeValue;
    logic [4:0]       queryIndex1;
    logic [4:0]       queryIndex2;
    logic             flagOutput1;
    logic             flagOutput2;
    logic [2:0]       occupancy;
    logic             errorFlag;

    register_writeback #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .reserveValid(reserveValid),
        .reserveIndex(reserveIndex),
        .reserveReady(reserveReady),
        .resultValid (resultValid),
        .resultIndex (resultIndex),
        .resultValue (resultValue),
        .regWriteW   (regWriteW),
        .resultReady (resultReady),
        .writeEnable (writeEnable),
        .writeIndex  (writeIndex),
        .writeValue  (writeValue),
        .queryIndex1 (queryIndex1),
        .queryIndex2 (queryIndex2),
        .flagOutput1 (flagOutput1),
        .flagOutput2 (flagOutput2),
        .occupancy   (occupancy),
        .errorFlag   (errorFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]       idx;
        logic [WIDTH-1:0] val;
    } ent_t;

    int         tests = 0;
    int         fails = 0;
    int         mcnt [32];
    int         owed [32];
    ent_t       mq [$];
    logic       m_we;
    logic [4:0] m_widx;
    logic [WIDTH-1:0] m_wval;
    logic       m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mcnt[i] = 0;
            owed[i] = 0;
        end
        mq.delete();
        m_we   = 1'b0;
        m_widx = '0;
        m_wval = '0;
        m_err  = 1'b0;
    endtask

    // One clock: check combinational outputs, advance model, check registers.
    task automatic cycle();
        ent_t e;
        logic rr;
        bit   racc;
        bit   pacc;
        #1;
        rr = !(reserveIndex != 0 && mcnt[reserveIndex] == 3);
        chk("reserveReady", reserveReady, rr);
        chk("resultReady", resultReady, mq.size() < DEPTH);
        chk("flag1", flagOutput1, mcnt[queryIndex1] == 0);
        chk("flag2", flagOutput2, mcnt[queryIndex2] == 0);
        chk("occupancy", occupancy, mq.size());
        @(posedge clk);
        #1;
        if (reset) begin
            model_clear();
        end else begin
            racc = reserveValid && rr && reserveIndex != 0;
            pacc = resultValid && mq.size() < DEPTH;
            if (m_we) begin
                if (mcnt[m_widx] == 0) m_err = 1'b1;
                mcnt[m_widx] = mcnt[m_widx] - 1;
            end
            if (racc) begin
                mcnt[reserveIndex] = mcnt[reserveIndex] + 1;
                owed[reserveIndex] = owed[reserveIndex] + 1;
            end
            for (int i = 0; i < 32; i++) begin
                if (mcnt[i] < 0) mcnt[i] = 0;
            end
            if (mq.size() > 0) begin
                e      = mq.pop_front();
                m_we   = 1'b1;
                m_widx = e.idx;
                m_wval = e.val;
            end else begin
                m_we = 1'b0;
            end
            if (pacc && regWriteW && resultIndex != 0) begin
                e.idx = resultIndex;
                e.val = resultValue;
                mq.push_back(e);
                if (owed[resultIndex] > 0) owed[resultIndex] = owed[resultIndex] - 1;
            end
        end
        chk("writeEnable", writeEnable, m_we);
        chk("writeIndex", writeIndex, m_widx);
        chk("writeValue", writeValue, m_wval);
        chk("errorFlag", errorFlag, m_err);
    endtask

    task automatic idle_inputs();
        reserveValid = 1'b0;
        resultValid  = 1'b0;
        regWriteW    = 1'b1;
    endtask

    task automatic push(input logic [4:0] idx, input logic [WIDTH-1:0] val);
        resultValid = 1'b1;
        regWriteW   = 1'b1;
        resultIndex = idx;
        resultValue = val;
    endtask

    initial begin
        logic [4:0] got [$];
        int         pick;
        int         off;

        reset        = 1'b1;
        reserveValid = 1'b0;
        reserveIndex = '0;
        resultValid  = 1'b0;
        resultIndex  = '0;
        resultValue  = '0;
        regWriteW    = 1'b0;
        queryIndex1  = '0;
        queryIndex2  = '0;
        model_clear();
        repeat (2) @(posedge clk);
        cycle();
        reset = 1'b0;
        chk("rst_we", writeEnable, 1'b0);
        chk("rst_occ", occupancy, 3'd0);
        chk("rst_err", errorFlag, 1'b0);
        cycle();

        // Reserve r5, push one cycle later, watch write and flag.
        queryIndex1  = 5;
        queryIndex2  = 0;
        reserveValid = 1'b1;
        reserveIndex = 5;
        cycle();
        reserveValid = 1'b0;
        push(5, 32'hDEADBEEF);
        cycle();
        idle_inputs();
        cycle();
        chk("t34_we", writeEnable, 1'b1);
        chk("t34_idx", writeIndex, 5'd5);
        chk("t34_val", writeValue, 32'hDEADBEEF);
        chk("t34_flag_pending", flagOutput1, 1'b0);
        cycle();
        chk("t34_flag_done", flagOutput1, 1'b1);
        chk("t34_we_drop", writeEnable, 1'b0);

        // Saturate r7's pending counter.
        queryIndex1  = 7;
        reserveValid = 1'b1;
        reserveIndex = 7;
        repeat (3) cycle();
        chk("t35_full", reserveReady, 1'b0);
        cycle();
        reserveValid = 1'b0;
        push(7, 32'h7000_0001);
        cycle();
        idle_inputs();
        cycle();
        cycle();
        chk("t35_ready", reserveReady, 1'b1);
        push(7, 32'h7000_0002);
        cycle();
        push(7, 32'h7000_0003);
        cycle();
        idle_inputs();
        repeat (3) cycle();
        chk("t35_flag", flagOutput1, 1'b1);

        // Back-to-back pushes must retire in order.
        for (int i = 1; i <= 4; i++) begin
            reserveValid = 1'b1;
            reserveIndex = 5'(i);
            cycle();
        end
        reserveValid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(5'(i), 32'hA000_0000 + 32'(i));
            cycle();
            if (writeEnable) got.push_back(writeIndex);
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (writeEnable) got.push_back(writeIndex);
        end
        chk("t36_count", got.size(), 4);
        for (int k = 0; k < got.size(); k++) begin
            chk("t36_order", got[k], 5'(k + 1));
        end

        // Discarded pushes leave no trace.
        queryIndex1 = 3;
        push(3, 32'h3333_3333);
        regWriteW = 1'b0;
        cycle();
        push(0, 32'h0000_0BAD);
        cycle();
        idle_inputs();
        cycle();
        chk("t37_we", writeEnable, 1'b0);
        chk("t37_occ", occupancy, 3'd0);
        chk("t37_flag", flagOutput1, 1'b1);

        // Same-edge reserve and retire of r9.
        queryIndex1  = 9;
        reserveValid = 1'b1;
        reserveIndex = 9;
        cycle();
        reserveValid = 1'b0;
        push(9, 32'h9999_0001);
        cycle();
        idle_inputs();
        cycle();
        chk("t38_we", writeEnable, 1'b1);
        reserveValid = 1'b1;
        reserveIndex = 9;
        cycle();
        reserveValid = 1'b0;
        chk("t38_flag", flagOutput1, 1'b0);
        chk("t38_err", errorFlag, 1'b0);
        push(9, 32'h9999_0002);
        cycle();
        idle_inputs();
        repeat (3) cycle();
        chk("t38_flag_done", flagOutput1, 1'b1);

        // Unreserved retire sets the error; reset mid-flight clears all.
        push(20, 32'h2020_2020);
        cycle();
        idle_inputs();
        repeat (2) cycle();
        chk("t39_err_set", errorFlag, 1'b1);
        queryIndex1  = 11;
        queryIndex2  = 12;
        reserveValid = 1'b1;
        reserveIndex = 11;
        cycle();
        reserveIndex = 12;
        cycle();
        reserveValid = 1'b0;
        push(11, 32'h1111_1111);
        cycle();
        push(12, 32'h1212_1212);
        cycle();
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t39_we", writeEnable, 1'b0);
        chk("t39_occ", occupancy, 3'd0);
        chk("t39_err", errorFlag, 1'b0);
        chk("t39_flag1", flagOutput1, 1'b1);
        chk("t39_flag2", flagOutput2, 1'b1);
        cycle();
        chk("t39_no_pulse", writeEnable, 1'b0);

        // Random traffic, biased towards results for reserved registers.
        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 149) == 0);
            reserveValid = $urandom_range(0, 1);
            reserveIndex = 5'($urandom_range(0, 7));
            resultValid  = $urandom_range(0, 1);
            regWriteW    = ($urandom_range(0, 9) != 0);
            resultValue  = $urandom;
            queryIndex1  = 5'($urandom_range(0, 7));
            queryIndex2  = 5'($urandom_range(0, 7));
            pick = -1;
            off  = $urandom_range(1, 31);
            for (int j = 0; j < 31; j++) begin
                if (pick < 0 && owed[((off + j - 1) % 31) + 1] > 0) begin
                    pick = ((off + j - 1) % 31) + 1;
                end
            end
            if (pick > 0 && $urandom_range(0, 9) != 0) begin
                resultIndex = 5'(pick);
            end else begin
                resultIndex = 5'($urandom_range(0, 7));
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
